// File: rtl/decoder_2x4_scan_ctrl_if.sv
// rtl/decoder_2x4_scan_ctrl_if.sv - control/status bundle between a host and the decoder select sequencer
//
// Purpose: groups the scanner controls (en, mode, start, dwell, blank,
// force_en, force_sel) and the registered decoder-side outputs (a, b,
// dec_en, busy, done) into one bundle.
// Modports:
//   master - host side: drives the controls, observes the outputs
//   slave  - sequencer side: receives the controls, drives the outputs
interface decoder_2x4_scan_ctrl_if #(
    parameter int DWELL_W = 16,
    parameter int BLANK_W = 8
);
    logic               en;
    logic               mode;
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic               force_en;
    logic [1:0]         force_sel;
    logic               a;
    logic               b;
    logic               dec_en;
    logic               busy;
    logic               done;

    modport master (
        output en, mode, start, dwell, blank, force_en, force_sel,
        input  a, b, dec_en, busy, done
    );

    modport slave (
        input  en, mode, start, dwell, blank, force_en, force_sel,
        output a, b, dec_en, busy, done
    );
endinterface

// File: rtl/decoder_2x4_scan_ctrl.sv
// rtl/decoder_2x4_scan_ctrl.sv - registered select sequencer driving a 2-to-4 decoder
//
// Purpose: steps the decoder select code {a,b} through 00,01,10,11 with a
// programmable dwell per code and an optional blanking gap, in continuous
// or single-sweep mode, with a manual force override.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of decoder_2x4_scan_ctrl_if (controls in, outputs out)
module decoder_2x4_scan_ctrl #(
    parameter int DWELL_W = 16,
    parameter int BLANK_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    decoder_2x4_scan_ctrl_if.slave        bus
);
    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             dec_en_q, dec_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             advance;
    logic             sweep_end;
    logic [CNT_W-1:0] dwell_ld;
    logic [CNT_W-1:0] blank_ld;

    // A dwell of zero still shows the code for one cycle.
    assign dwell_ld = (bus.dwell == '0) ? CNT_W'(1) : CNT_W'(bus.dwell);
    assign blank_ld = CNT_W'(bus.blank);

    // The counter holds the cycles left in the current state including the
    // present one, so the state ends on the edge where it reads 1.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        advance   = 1'b0;
        sweep_end = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else if (bus.force_en) begin
            // Frozen: state, index and remaining count are held.
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.mode || bus.start) begin
                        state_d = ST_DRIVE;
                        idx_d   = 2'd0;
                        cnt_d   = dwell_ld;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (bus.blank != '0) begin
                        state_d = ST_BLANK;
                        cnt_d   = blank_ld;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase

            if (advance) begin
                if (idx_q == 2'd3) begin
                    sweep_end = 1'b1;
                    // mode is only looked at here, so a mid-sweep switch to
                    // single mode lets the current sweep finish.
                    if (!bus.mode) begin
                        state_d = ST_DRIVE;
                        idx_d   = 2'd0;
                        cnt_d   = dwell_ld;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = dwell_ld;
                end
            end
        end
    end

    // Outputs are registered from the next state so they track it with
    // exactly one edge of latency from the sampled inputs.
    always_comb begin
        a_d      = 1'b0;
        b_d      = 1'b0;
        dec_en_d = 1'b0;
        if (bus.force_en) begin
            a_d      = bus.force_sel[1];
            b_d      = bus.force_sel[0];
            dec_en_d = 1'b1;
        end else if (state_d != ST_IDLE) begin
            a_d      = idx_d[1];
            b_d      = idx_d[0];
            dec_en_d = (state_d == ST_DRIVE);
        end
        busy_d = (state_d != ST_IDLE);
        done_d = sweep_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            dec_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dec_en_q <= dec_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.dec_en = dec_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_decoder_2x4_scan_ctrl.sv
// tb/tb_decoder_2x4_scan_ctrl.sv - self-checking bench for decoder_2x4_scan_ctrl
module tb_decoder_2x4_scan_ctrl;
    logic clk;
    logic rst;

    decoder_2x4_scan_ctrl_if #(.DWELL_W(16), .BLANK_W(8)) bus ();

    decoder_2x4_scan_ctrl #(.DWELL_W(16), .BLANK_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packs {a, b, dec_en, busy, done} seen after the edge that samples
    // this vector's inputs.
    typedef struct {
        logic        rst;
        logic        en;
        logic        mode;
        logic        start;
        logic        fe;
        logic [1:0]  fs;
        logic [15:0] dwell;
        logic [7:0]  blank;
        logic [4:0]  exp;
        string       name;
    } vec_t;

    vec_t vq[$];
    vec_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Closed-form expected scan output k edges after the scan starts.
    function automatic logic [4:0] scan_exp(int k, int d, int bl);
        int dd, p, code, w;
        logic de, dn;
        logic [1:0] c2;
        dd   = (d == 0) ? 1 : d;
        p    = dd + bl;
        code = (k / p) % 4;
        w    = k % p;
        de   = (w < dd);
        dn   = (k > 0) && ((k % (4 * p)) == 0);
        c2   = code[1:0];
        return {c2[1], c2[0], de, 1'b1, dn};
    endfunction

    task automatic add(input logic r, input logic en, input logic mode, input logic start,
                       input logic fe, input logic [1:0] fs, input int dwell, input int blank,
                       input logic [4:0] exp, input string name);
        vec_t v;
        v.rst = r; v.en = en; v.mode = mode; v.start = start;
        v.fe = fe; v.fs = fs; v.dwell = 16'(dwell); v.blank = 8'(blank);
        v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    initial begin
        vec_t cur;
        logic [4:0] got;
        logic [4:0] rst_got;
        bit seen_done;

        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 1'b0; bus.start = 1'b0;
        bus.dwell = '0; bus.blank = '0; bus.force_en = 1'b0; bus.force_sel = 2'b00;

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_got = {bus.a, bus.b, bus.dec_en, bus.busy, bus.done};
        n_cmp++;
        if (rst_got !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: {a,b,dec_en,busy,done} got %b expected 00000", rst_got);
        end

        // Reset held with en=1, then continuous dwell=3 blank=0.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 2'b00, 3, 0, 5'b00000, "reset_en_held");
        for (int k = 0; k < 28; k++) add(0, 1, 0, 0, 0, 2'b00, 3, 0, scan_exp(k, 3, 0), "cont_d3_b0");
        // Reset mid-sweep overrides en and force.
        add(1, 1, 0, 0, 1, 2'b11, 3, 0, 5'b00000, "reset_over_force");

        // Single sweep dwell=2 blank=1 with a second start mid-sweep.
        add(0, 1, 1, 0, 0, 2'b00, 2, 1, 5'b00000, "single_wait_start");
        add(0, 1, 1, 0, 0, 2'b00, 2, 1, 5'b00000, "single_wait_start");
        for (int k = 0; k < 12; k++)
            add(0, 1, 1, (k == 0 || k == 5), 0, 2'b00, 2, 1, scan_exp(k, 2, 1), "single_d2_b1");
        add(0, 1, 1, 0, 0, 2'b00, 2, 1, 5'b00001, "single_done");
        add(0, 1, 1, 0, 0, 2'b00, 2, 1, 5'b00000, "single_idle");
        add(0, 1, 1, 0, 0, 2'b00, 2, 1, 5'b00000, "single_idle");

        // dwell=0 blank=0: one cycle per code.
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000, "reset");
        for (int k = 0; k < 9; k++) add(0, 1, 0, 0, 0, 2'b00, 0, 0, scan_exp(k, 0, 0), "cont_d0_b0");

        // Force mid-DRIVE of code 01 with 2 of 5 cycles left.
        add(1, 0, 0, 0, 0, 2'b00, 5, 0, 5'b00000, "reset");
        for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 0, 2'b00, 5, 0, scan_exp(k, 5, 0), "pre_force");
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 2'b11, 5, 0, 5'b11110, "force_11");
        for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 2'b00, 5, 0, 5'b01110, "resume_01");
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 2'b00, 5, 0, 5'b10110, "after_10");
        add(0, 1, 0, 0, 0, 2'b00, 5, 0, 5'b11110, "after_11");
        // en=0 with force: forced output, FSM to IDLE.
        add(0, 0, 0, 0, 1, 2'b10, 5, 0, 5'b10100, "force_en_low");
        add(0, 0, 0, 0, 0, 2'b00, 5, 0, 5'b00000, "idle_after_force");

        // en dropped in BLANK of code 2, then restart.
        add(1, 0, 0, 0, 0, 2'b00, 2, 2, 5'b00000, "reset");
        for (int k = 0; k < 11; k++) add(0, 1, 0, 0, 0, 2'b00, 2, 2, scan_exp(k, 2, 2), "cont_d2_b2");
        add(0, 0, 0, 1, 0, 2'b00, 2, 2, 5'b00000, "en_drop");
        add(0, 0, 0, 0, 0, 2'b00, 2, 2, 5'b00000, "en_low");
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 0, 2'b00, 2, 2, scan_exp(k, 2, 2), "restart");

        // mode 0->1 mid-sweep finishes the sweep then idles.
        add(1, 0, 0, 0, 0, 2'b00, 1, 0, 5'b00000, "reset");
        for (int k = 0; k < 4; k++) add(0, 1, (k >= 2), 0, 0, 2'b00, 1, 0, scan_exp(k, 1, 0), "mode_switch");
        add(0, 1, 1, 0, 0, 2'b00, 1, 0, 5'b00001, "mode_switch_done");
        add(0, 1, 1, 0, 0, 2'b00, 1, 0, 5'b00000, "mode_switch_idle");

        foreach (vq[i]) begin
            @(negedge clk);
            rst           = vq[i].rst;
            bus.en        = vq[i].en;
            bus.mode      = vq[i].mode;
            bus.start     = vq[i].start;
            bus.force_en  = vq[i].fe;
            bus.force_sel = vq[i].fs;
            bus.dwell     = vq[i].dwell;
            bus.blank     = vq[i].blank;
            exp_q.push_back(vq[i]);
            @(posedge clk);
            #1;
            cur = exp_q.pop_front();
            got = {bus.a, bus.b, bus.dec_en, bus.busy, bus.done};
            n_cmp++;
            if (got !== cur.exp) begin
                n_err++;
                $display("FAIL %s step %0d: {a,b,dec_en,busy,done} got %b expected %b",
                         cur.name, i, got, cur.exp);
            end
        end

        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b1; bus.mode = 1'b0; bus.start = 1'b0;
        bus.force_en = 1'b0; bus.dwell = 16'd1; bus.blank = 8'd0;
        seen_done = 1'b0;
        for (int t = 0; t < 20 && !seen_done; t++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (!seen_done) begin
            n_err++;
            $display("FAIL done_wait: no done pulse within 20 cycles of continuous scan");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decoder_2x4_scan_ctrl.md
# decoder_2x4_scan_ctrl

Registered select sequencer that sits directly upstream of the 2-to-4 dataflow decoder and drives its `a`/`b` select inputs. It steps the select code 00→01→10→11 with a programmable dwell time per code and an optional blanking gap between codes, for multiplexed display or row scanning. It supports continuous scanning, single-sweep operation, and a manual force override. The decoder's one-hot outputs are gated by `dec_en`.

## Interface
- `DWELL_W`, 16, width of the dwell count input
- `BLANK_W`, 8, width of the blank count input
- `clk`  in  1  single system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  scanner enable; low forces IDLE
- `mode`  in  1  0 = continuous scan, 1 = single sweep
- `start`  in  1  single-sweep trigger, sampled in IDLE only
- `dwell`  in  DWELL_W  cycles each code is driven; 0 is treated as 1
- `blank`  in  BLANK_W  gap cycles after each code; 0 means no gap
- `force_en`  in  1  manual override
- `force_sel`  in  2  code driven while `force_en`=1 ({a,b})
- `a`  out  1  decoder select MSB, registered
- `b`  out  1  decoder select LSB, registered
- `dec_en`  out  1  decoder output enable, registered
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse at the end of each full sweep

## Operation
- The code index `idx[1:0]` maps to outputs as `{a,b}` = `idx`.
- States:
  - IDLE: `a`=`b`=0, `dec_en`=0, `busy`=0.
  - DRIVE: `dec_en`=1, `{a,b}`=`idx`.
  - BLANK: `dec_en`=0, `{a,b}` holds `idx`.
- IDLE→DRIVE with `idx`=0:
  - when `en`=1 and `mode`=0;
  - when `en`=1, `mode`=1 and `start`=1.
- Entering DRIVE loads the counter with max(`dwell`,1). DRIVE lasts exactly that many cycles.
- At the end of DRIVE:
  - if `blank`≠0, go to BLANK, loading the counter with `blank`; BLANK lasts exactly `blank` cycles;
  - if `blank`=0, advance immediately.
- Advance after code 0, 1 or 2: `idx`+1, enter DRIVE.
- Advance after code 3:
  - `done` pulses for 1 cycle;
  - continuous mode: `idx` wraps to 0 and the FSM re-enters DRIVE with no extra gap cycle;
  - single mode: return to IDLE.
- `dwell` and `blank` are sampled only on counter load. Mid-state changes take effect at the next load.
- `mode` is sampled only at the advance after code 3. Switching 0→1 mid-sweep finishes the current sweep, then goes to IDLE.
- `en`=0 in any state: next cycle IDLE, `idx`=0, counter cleared, no `done`.
- `start` outside IDLE, or with `mode`=0, is ignored.
- `force_en`=1 (highest priority below `rst`):
  - next cycle `{a,b}`=`force_sel`, `dec_en`=1;
  - FSM state, `idx` and counter freeze;
  - `busy` reflects the frozen state;
  - `done` is suppressed.
- On `force_en` falling, the FSM resumes its frozen state and remaining count, and outputs revert next cycle.
- Counter width is max(`DWELL_W`,`BLANK_W`). No overflow is possible because the counter counts down only.

## Timing
- Reset values: `a`=0, `b`=0, `dec_en`=0, `busy`=0, `done`=0, FSM IDLE, `idx`=0.
- All outputs are registered, with 1-cycle latency from any sampled input to its output.
- Continuous mode with `en` rising at edge t: from edge t+1, `{a,b}`=00 and `dec_en`=1.
- Sweep length is 4·(max(`dwell`,1)+`blank`) cycles.
- `done` is high in the cycle after the last cycle of code 3's DRIVE or BLANK. In continuous mode this is the same cycle the new code 0 appears.
- `rst` asserted mid-sweep: all outputs return to their reset values at the next edge, overriding `en` and `force_en`.
- Simultaneous events:
  - `en`=0 and `force_en`=1 together: forced output is shown and the FSM goes to IDLE.
  - `start`=1 with `en`=0: ignored.

## Test plan
- Reset with `en`=1 held: all outputs 0 while `rst`=1. The first `{a,b}`=00 with `dec_en`=1 appears one cycle after `rst` falls.
- Continuous, `dwell`=3, `blank`=0: `{a,b}` sequence 00×3, 01×3, 10×3, 11×3, 00…; `dec_en` constantly 1; `done` pulses every 12 cycles, coincident with each return to 00.
- Single sweep, `dwell`=2, `blank`=1, `start` pulse: pattern per code is 2 cycles with `dec_en`=1 then 1 with `dec_en`=0, over 12 cycles. Then `done`=1 for 1 cycle, then IDLE with `busy`=0. A second `start` during the sweep is ignored.
- Edge counts, `dwell`=0, `blank`=0: each code lasts 1 cycle; `{a,b}` is 00,01,10,11,00; `done` every 4 cycles.
- Force mid-DRIVE, code 01 with 2 of 5 cycles remaining, `force_sel`=11 for 4 cycles: outputs are 11 with `dec_en`=1 for 4 cycles, then 01 for exactly 2 more cycles, then 10.
- `en` dropped during BLANK of code 2: next cycle IDLE with outputs 0 and no `done`. `en` reasserted: the scan restarts at 00.
